// File: rtl/ex_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit_if
// Description : Request/result bundle between the EX stage and the
//               multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] operand_1;
    logic [DATA_WIDTH-1:0] operand_2;
    logic [DATA_WIDTH-1:0] hi_in;
    logic [DATA_WIDTH-1:0] lo_in;
    logic                  flush;
    logic                  stall_req;
    logic                  done;
    logic                  write_hilo_en;
    logic [DATA_WIDTH-1:0] hi_out;
    logic [DATA_WIDTH-1:0] lo_out;

    modport master (
        output start, op, operand_1, operand_2, hi_in, lo_in, flush,
        input  stall_req, done, write_hilo_en, hi_out, lo_out
    );

    modport slave (
        input  start, op, operand_1, operand_2, hi_in, lo_in, flush,
        output stall_req, done, write_hilo_en, hi_out, lo_out
    );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit
// Description : Multi-cycle MULT/MULTU/DIV/DIVU unit writing HI/LO; MADD/MSUB
//               accumulate ops are built only when MULDIV_MADD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    ex_muldiv_unit_if.slave    bus
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(W + MUL_STAGES + 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     a_q, b_q;
    logic             uns_q;
    logic [W-1:0]     quo_q, rem_q, dvs_q;
    logic             qneg_q, rneg_q, dz_q;
    logic [W-1:0]     hi_q, lo_q;

    logic             op_ok, accept, is_div_in, finish;
    logic             mul_hit, div_hit;
    logic [CNT_W-1:0] mul_last;
    logic             dvd_neg, dvs_neg;
    logic [W-1:0]     abs_a, abs_b;
    logic [2*W-1:0]   a_ext, b_ext, prod, mul_res, div_res;
    logic [W:0]       trial, diff;
    logic [W-1:0]     q_fix, r_fix;
    logic             done_w, stall_w;

`ifdef MULDIV_MADD_EN
    logic             acc_en_q, sub_q;
    logic [2*W-1:0]   acc_q;
    assign op_ok    = 1'b1;
    assign mul_last = acc_en_q ? CNT_W'(MUL_STAGES) : CNT_W'(MUL_STAGES - 1);
    assign mul_res  = !acc_en_q ? prod : (sub_q ? acc_q - prod : acc_q + prod);
`else
    assign op_ok    = ~bus.op[2];
    assign mul_last = CNT_W'(MUL_STAGES - 1);
    assign mul_res  = prod;
`endif

    assign accept    = bus.start & ~bus.flush & op_ok & (state_q == S_IDLE);
    assign is_div_in = (bus.op[2:1] == 2'b01);

    // Divider works on magnitudes; signs are reapplied when the result is written.
    assign dvd_neg = ~bus.op[0] & bus.operand_1[W-1];
    assign dvs_neg = ~bus.op[0] & bus.operand_2[W-1];
    assign abs_a   = dvd_neg ? (~bus.operand_1 + W'(1)) : bus.operand_1;
    assign abs_b   = dvs_neg ? (~bus.operand_2 + W'(1)) : bus.operand_2;

    assign a_ext = uns_q ? {{W{1'b0}}, a_q} : {{W{a_q[W-1]}}, a_q};
    assign b_ext = uns_q ? {{W{1'b0}}, b_q} : {{W{b_q[W-1]}}, b_q};
    assign prod  = a_ext * b_ext;

    assign trial   = {rem_q, quo_q[W-1]};
    assign diff    = trial - {1'b0, dvs_q};
    assign q_fix   = qneg_q ? -quo_q : quo_q;
    assign r_fix   = rneg_q ? -rem_q : rem_q;
    assign div_res = dz_q ? {a_q, {W{1'b1}}} : {r_fix, q_fix};

    assign mul_hit = (cnt_q == mul_last);
    assign div_hit = dz_q | (cnt_q == CNT_W'(W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = is_div_in ? S_DIV : S_MUL;
            S_MUL:   if (mul_hit) state_d = S_DONE;
            S_DIV:   if (div_hit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) state_d = S_IDLE;
    end

    always_comb begin
        done_w  = (state_q == S_DONE);
        stall_w = accept | (state_q == S_MUL) | (state_q == S_DIV);
    end

    // A flushed op never reaches DONE, so hi/lo keep their previous result.
    assign finish = (state_d == S_DONE) & (state_q != S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            uns_q  <= 1'b0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
`ifdef MULDIV_MADD_EN
            acc_en_q <= 1'b0;
            sub_q    <= 1'b0;
            acc_q    <= '0;
`endif
        end else begin
            if (accept) begin
                cnt_q  <= '0;
                a_q    <= bus.operand_1;
                b_q    <= bus.operand_2;
                uns_q  <= bus.op[0];
                quo_q  <= abs_a;
                rem_q  <= '0;
                dvs_q  <= abs_b;
                qneg_q <= dvd_neg ^ dvs_neg;
                rneg_q <= dvd_neg;
                dz_q   <= (bus.operand_2 == '0);
`ifdef MULDIV_MADD_EN
                acc_en_q <= bus.op[2];
                sub_q    <= bus.op[1];
                acc_q    <= {bus.hi_in, bus.lo_in};
`endif
            end else if (state_q == S_MUL || state_q == S_DIV) begin
                cnt_q <= cnt_q + 1'b1;
                if (state_q == S_DIV && cnt_q < CNT_W'(W)) begin
                    if (!diff[W]) begin
                        rem_q <= diff[W-1:0];
                        quo_q <= {quo_q[W-2:0], 1'b1};
                    end else begin
                        rem_q <= trial[W-1:0];
                        quo_q <= {quo_q[W-2:0], 1'b0};
                    end
                end
            end
            if (finish) begin
                {hi_q, lo_q} <= (state_q == S_DIV) ? div_res : mul_res;
            end
        end
    end

    assign bus.done          = done_w;
    assign bus.write_hilo_en = done_w;
    assign bus.stall_req     = stall_w;
    assign bus.hi_out        = hi_q;
    assign bus.lo_out        = lo_q;
endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv_unit
// Description : Randomized self-checking bench for ex_muldiv_unit against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;
    localparam int W  = 32;
    localparam int MS = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_muldiv_unit_if #(.DATA_WIDTH(W)) bus();

    ex_muldiv_unit #(.DATA_WIDTH(W), .MUL_STAGES(MS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] hi,
                                               input logic [31:0] lo);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (op[2:1] == 2'b01) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (op[0]) begin
                p = ua / ub;
                return {32'(ua % ub), p[31:0]};
            end
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        p = op[0] ? ua * ub : 64'(sa * sb);
        if (!op[2]) return p;
        return op[1] ? {hi, lo} - p : {hi, lo} + p;
    endfunction

    function automatic bit op_valid(input logic [2:0] op);
`ifdef MULDIV_MADD_EN
        return 1'b1;
`else
        return !op[2];
`endif
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] b);
        if (op[2:1] == 2'b01) return (b == 32'd0) ? 1 : W + 1;
        return op[2] ? MS + 1 : MS;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
        logic [63:0] exp_res, prev_out;
        bit          valid, seen, stall_bad;
        int          lat, budget;
        valid   = op_valid(op);
        exp_res = ref_result(op, a, b, hi, lo);
        seen = 1'b0; stall_bad = 1'b0; lat = -1;
        budget = valid ? W + 6 : 6;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.operand_1 = a; bus.operand_2 = b;
        bus.hi_in = hi;   bus.lo_in = lo;
        #1;
        check({tag, "/stall_start"}, 64'(bus.stall_req), 64'(valid));
        prev_out = {bus.hi_out, bus.lo_out};
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = 3'($urandom); bus.operand_1 = $urandom;
        bus.operand_2 = $urandom; bus.hi_in = $urandom; bus.lo_in = $urandom;
        if (bus.stall_req !== valid || bus.done !== 1'b0) stall_bad = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                seen = 1'b1; lat = k;
                break;
            end
            if (bus.stall_req !== valid) stall_bad = 1'b1;
        end
        check({tag, "/stall_busy"}, 64'(stall_bad), 64'd0);
        if (valid) begin
            check({tag, "/latency"}, 64'(lat), 64'(ref_latency(op, b)));
            check({tag, "/result"}, {bus.hi_out, bus.lo_out}, exp_res);
            check({tag, "/done_flags"}, {62'd0, bus.write_hilo_en, bus.stall_req}, 64'd2);
            @(posedge clk); #1;
            check({tag, "/done_pulse"}, {bus.hi_out, bus.lo_out, 31'd0, bus.done} ^ {exp_res, 32'd0},
                  64'd0);
        end else begin
            check({tag, "/no_done"}, 64'(seen), 64'd0);
            check({tag, "/held"}, {bus.hi_out, bus.lo_out}, prev_out);
        end
    endtask

    initial begin
        logic [63:0] prev;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        bus.start = 1'b0; bus.op = '0; bus.operand_1 = '0; bus.operand_2 = '0;
        bus.hi_in = '0;   bus.lo_in = '0; bus.flush = 1'b0;
        #12;
        check("reset_outputs", {bus.hi_out, bus.lo_out} | 64'({bus.done, bus.write_hilo_en, bus.stall_req}),
              64'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op("mult",   3'b000, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0);
        run_op("multu",  3'b001, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0);
        run_op("div",    3'b010, 32'hFFFF_FFF9, 32'h2, 32'h0, 32'h0);
        run_op("div_ovf",3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0);
        run_op("divu_z", 3'b011, 32'h64, 32'h0, 32'h0, 32'h0);
        run_op("div_z",  3'b010, 32'hFFFF_FF00, 32'h0, 32'h0, 32'h0);
        run_op("madd",   3'b100, 32'd3, 32'd4, 32'd0, 32'd10);
        run_op("msubu",  3'b111, 32'd1, 32'd1, 32'd0, 32'd0);

        // flush mid-DIVU: no done, outputs held, unit idle again
        @(negedge clk);
        prev = {bus.hi_out, bus.lo_out};
        bus.start = 1'b1; bus.op = 3'b011; bus.operand_1 = 32'd1000; bus.operand_2 = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            check("flush/no_early_done", 64'(bus.done), 64'd0);
        end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush/stall_low", 64'(bus.stall_req), 64'd0);
        check("flush/held", {bus.hi_out, bus.lo_out}, prev);
        repeat (W) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0) check("flush/late_done", 64'(bus.done), 64'd0);
        end
        run_op("after_flush", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'h0, 32'h0);

        // flush together with start in IDLE drops the start
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'b000;
        #1 check("flush_start/stall", 64'(bus.stall_req), 64'd0);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        check("flush_start/idle", 64'({bus.stall_req, bus.done}), 64'd0);
        @(posedge clk); #1;
        check("flush_start/no_done", 64'({bus.stall_req, bus.done}), 64'd0);

        // asynchronous reset mid-DIV clears everything immediately
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b010; bus.operand_1 = 32'd12345; bus.operand_2 = 32'd11;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_mid/outputs",
                 {bus.hi_out, bus.lo_out} | 64'({bus.done, bus.write_hilo_en, bus.stall_req}), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (W + 3) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0) check("rst_mid/late_done", 64'(bus.done), 64'd0);
        end
        run_op("after_rst", 3'b011, 32'd1000, 32'd7, 32'h0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom);
            ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 9));
                2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 9));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, $urandom, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
